// File: rtl/rt_pkg.sv
// Shared definitions for the ray-tracing pipeline: default resolution,
// pixel width, pixel coordinate types and the frame scheduler state encoding.
package rt_pkg;

   localparam int RT_H_RES = 640;
   localparam int RT_V_RES = 480;
   localparam int RT_PIX_W = 4;

   typedef logic [9:0] pix_x_t;
   typedef logic [8:0] pix_y_t;

   typedef enum logic [2:0] {
      S_IDLE      = 3'd0,
      S_ISSUE     = 3'd1,
      S_WAIT_ACK  = 3'd2,
      S_WAIT_DONE = 3'd3,
      S_WRITE     = 3'd4,
      S_DONE      = 3'd5
   } sched_state_t;

endpackage

// File: rtl/rt_frame_scheduler.sv
// Frame-level initiator: walks the frame in raster order, issues one pixel
// request at a time to the ray-tracing core and writes each result to the
// framebuffer at Y*H_RES+X (kept as a running counter, no multiplier).
//
// state     | meaning
// ----------+------------------------------------------------------------
// IDLE      | waiting for START; counters hold last frame's values
// ISSUE     | waiting for core READY, then pulse ENABLE with current X/Y
// WAIT_ACK  | waiting for core to drop READY; re-issue after ACK_TIMEOUT
// WAIT_DONE | waiting for READY to return; capture pixel and address
// WRITE     | FB_WE held until a non-stalled cycle, then advance raster
// DONE      | one-cycle FRAME_DONE pulse, BUSY low
module rt_frame_scheduler
   import rt_pkg::*;
#(
   parameter int H_RES       = RT_H_RES,
   parameter int V_RES       = RT_V_RES,
   parameter int PIX_W       = RT_PIX_W,
   parameter int ADDR_W      = 19,
   parameter int ACK_TIMEOUT = 8
) (
   input  logic              i_clk,
   input  logic              i_rst,
   input  logic              i_start,
   output logic              o_busy,
   output logic              o_frame_done,
   output logic [7:0]        o_frame_count,
   output logic              o_core_enable,
   output logic [9:0]        o_core_x,
   output logic [8:0]        o_core_y,
   input  logic              i_core_ready,
   input  logic [PIX_W-1:0]  i_core_pixel,
   output logic              o_fb_we,
   output logic [ADDR_W-1:0] o_fb_addr,
   output logic [PIX_W-1:0]  o_fb_data,
   input  logic              i_fb_stall
);

   localparam int CNT_W = (ACK_TIMEOUT > 1) ? $clog2(ACK_TIMEOUT) : 1;
   localparam logic [CNT_W-1:0] ACK_LOAD = CNT_W'(ACK_TIMEOUT - 1);
   localparam pix_x_t X_LAST = pix_x_t'(H_RES - 1);
   localparam pix_y_t Y_LAST = pix_y_t'(V_RES - 1);

   sched_state_t      r_state;
   sched_state_t      w_next;
   pix_x_t            r_x;
   pix_y_t            r_y;
   logic [ADDR_W-1:0] r_addr;
   logic [CNT_W-1:0]  r_ack_cnt;
   logic              r_core_enable;
   logic [ADDR_W-1:0] r_fb_addr;
   logic [PIX_W-1:0]  r_fb_data;
   logic [7:0]        r_frame_count;
   logic              w_last;
   logic              w_write_done;

   assign w_last = (r_x == X_LAST) && (r_y == Y_LAST);

   // State register
   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         r_state <= S_IDLE;
      end else begin
         r_state <= w_next;
      end
   end

   // Next-state logic; a high READY in WAIT_ACK only ever counts toward the timeout
   always_comb begin
      w_next       = r_state;
      w_write_done = 1'b0;
      unique case (r_state)
         S_IDLE: begin
            if (i_start) w_next = S_ISSUE;
         end
         S_ISSUE: begin
            if (i_core_ready) w_next = S_WAIT_ACK;
         end
         S_WAIT_ACK: begin
            if (!i_core_ready) begin
               w_next = S_WAIT_DONE;
            end else if (r_ack_cnt == '0) begin
               w_next = S_ISSUE;
            end
         end
         S_WAIT_DONE: begin
            if (i_core_ready) w_next = S_WRITE;
         end
         S_WRITE: begin
            if (!i_fb_stall) begin
               w_write_done = 1'b1;
               w_next       = w_last ? S_DONE : S_ISSUE;
            end
         end
         S_DONE: begin
            w_next = S_IDLE;
         end
         default: begin
            w_next = S_IDLE;
         end
      endcase
   end

   // Datapath: raster counters, ack timer, request pulse, result capture, frame counter
   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         r_x           <= '0;
         r_y           <= '0;
         r_addr        <= '0;
         r_ack_cnt     <= '0;
         r_core_enable <= 1'b0;
         r_fb_addr     <= '0;
         r_fb_data     <= '0;
         r_frame_count <= '0;
      end else begin
         r_core_enable <= (r_state == S_ISSUE) && i_core_ready;

         if ((r_state == S_IDLE) && i_start) begin
            r_x    <= '0;
            r_y    <= '0;
            r_addr <= '0;
         end

         if (r_state == S_ISSUE) begin
            r_ack_cnt <= ACK_LOAD;
         end else if ((r_state == S_WAIT_ACK) && (r_ack_cnt != '0)) begin
            r_ack_cnt <= r_ack_cnt - CNT_W'(1);
         end

         if ((r_state == S_WAIT_DONE) && i_core_ready) begin
            r_fb_data <= i_core_pixel;
            r_fb_addr <= r_addr;
         end

         if (w_write_done) begin
            if (w_last) begin
               r_frame_count <= r_frame_count + 8'd1;
            end else begin
               r_addr <= r_addr + ADDR_W'(1);
               if (r_x == X_LAST) begin
                  r_x <= '0;
                  r_y <= r_y + 9'd1;
               end else begin
                  r_x <= r_x + 10'd1;
               end
            end
         end
      end
   end

   assign o_busy        = (r_state == S_ISSUE) || (r_state == S_WAIT_ACK) ||
                          (r_state == S_WAIT_DONE) || (r_state == S_WRITE);
   assign o_frame_done  = (r_state == S_DONE);
   assign o_fb_we       = (r_state == S_WRITE);
   assign o_frame_count = r_frame_count;
   assign o_core_enable = r_core_enable;
   assign o_core_x      = r_x;
   assign o_core_y      = r_y;
   assign o_fb_addr     = r_fb_addr;
   assign o_fb_data     = r_fb_data;

endmodule

// File: tb/tb_rt_frame_scheduler.sv
// Directed bench for rt_frame_scheduler on a 4x3 frame with a 3-cycle core
// model returning X^Y.
module tb_rt_frame_scheduler;

   localparam int H    = 4;
   localparam int V    = 3;
   localparam int AW   = 19;
   localparam int PW   = 4;
   localparam int TO   = 8;
   localparam int NPIX = H * V;

   logic          clk   = 1'b0;
   logic          rst   = 1'b1;
   logic          start = 1'b0;
   logic          stall = 1'b0;
   logic          core_ready = 1'b1;
   logic [PW-1:0] core_pixel = '0;

   logic          busy, frame_done, core_enable, fb_we;
   logic [7:0]    frame_count;
   logic [9:0]    core_x;
   logic [8:0]    core_y;
   logic [AW-1:0] fb_addr;
   logic [PW-1:0] fb_data;

   int n_err = 0;
   int n_chk = 0;

   rt_frame_scheduler #(
      .H_RES(H), .V_RES(V), .PIX_W(PW), .ADDR_W(AW), .ACK_TIMEOUT(TO)
   ) dut (
      .i_clk(clk), .i_rst(rst), .i_start(start),
      .o_busy(busy), .o_frame_done(frame_done), .o_frame_count(frame_count),
      .o_core_enable(core_enable), .o_core_x(core_x), .o_core_y(core_y),
      .i_core_ready(core_ready), .i_core_pixel(core_pixel),
      .o_fb_we(fb_we), .o_fb_addr(fb_addr), .o_fb_data(fb_data),
      .i_fb_stall(stall)
   );

   always #5 clk = ~clk;

   // Core model: 3-cycle latency, result X^Y; can ignore one chosen request
   int   ignore_idx   = -1;
   int   core_en_seen = 0;
   int   core_lat     = 0;
   logic core_busy    = 1'b0;
   always @(posedge clk) begin
      if (core_busy) begin
         if (core_lat <= 1) begin
            core_ready <= 1'b1;
            core_busy  <= 1'b0;
         end else begin
            core_lat <= core_lat - 1;
         end
      end else if (core_enable) begin
         core_en_seen <= core_en_seen + 1;
         if (core_en_seen != ignore_idx) begin
            core_ready <= 1'b0;
            core_busy  <= 1'b1;
            core_lat   <= 3;
            core_pixel <= core_x[3:0] ^ core_y[3:0];
         end
      end
   end

   // Monitor: completed writes, request pulses and frame-done pulses
   logic [AW-1:0] wq_addr[$];
   logic [PW-1:0] wq_data[$];
   int            en_cyc[$];
   logic [9:0]    en_x[$];
   logic [8:0]    en_y[$];
   int            cyc        = 0;
   int            done_total = 0;
   int            en_double  = 0;
   logic          prev_en    = 1'b0;
   always @(negedge clk) begin
      cyc <= cyc + 1;
      if (fb_we && !stall) begin
         wq_addr.push_back(fb_addr);
         wq_data.push_back(fb_data);
      end
      if (frame_done) done_total <= done_total + 1;
      if (core_enable) begin
         en_cyc.push_back(cyc);
         en_x.push_back(core_x);
         en_y.push_back(core_y);
         if (prev_en) en_double <= en_double + 1;
      end
      prev_en <= core_enable;
   end

   task automatic tick();
      @(negedge clk);
      #1;
   endtask

   task automatic drive_edge();
      @(posedge clk);
      #1;
   endtask

   task automatic pulse_start();
      drive_edge();
      start = 1'b1;
      drive_edge();
      start = 1'b0;
   endtask

   task automatic wait_done(input int budget);
      bit seen;
      seen = 1'b0;
      for (int c = 0; c < budget; c++) begin
         tick();
         if (frame_done) begin
            seen = 1'b1;
            break;
         end
      end
      if (!seen) begin
         n_chk++;
         n_err++;
         $display("FAIL wait_done: frame_done not seen within %0d cycles", budget);
      end
   endtask

   task automatic run_frame();
      pulse_start();
      wait_done(3000);
   endtask

   task automatic do_reset();
      drive_edge();
      rst = 1'b1;
      drive_edge();
      drive_edge();
      rst = 1'b0;
   endtask

   task automatic test_reset();
      rst = 1'b1;
      repeat (3) tick();
      n_chk++; if (busy !== 1'b0) begin n_err++; $display("FAIL reset_busy: got %0d expected 0", busy); end
      n_chk++; if (frame_done !== 1'b0) begin n_err++; $display("FAIL reset_done: got %0d expected 0", frame_done); end
      n_chk++; if (frame_count !== 8'd0) begin n_err++; $display("FAIL reset_count: got %0d expected 0", frame_count); end
      n_chk++; if (core_enable !== 1'b0) begin n_err++; $display("FAIL reset_enable: got %0d expected 0", core_enable); end
      n_chk++; if (core_x !== 10'd0) begin n_err++; $display("FAIL reset_x: got %0d expected 0", core_x); end
      n_chk++; if (core_y !== 9'd0) begin n_err++; $display("FAIL reset_y: got %0d expected 0", core_y); end
      n_chk++; if (fb_we !== 1'b0) begin n_err++; $display("FAIL reset_we: got %0d expected 0", fb_we); end
      n_chk++; if (fb_addr !== '0) begin n_err++; $display("FAIL reset_addr: got %0d expected 0", fb_addr); end
      n_chk++; if (fb_data !== '0) begin n_err++; $display("FAIL reset_data: got %0d expected 0", fb_data); end
      drive_edge();
      rst = 1'b0;
      tick();
   endtask

   task automatic test_basic_frame();
      int bw, bd, be;
      logic [PW-1:0] exp_d;
      bw = wq_addr.size();
      bd = done_total;
      be = en_cyc.size();
      pulse_start();
      tick();
      n_chk++; if (busy !== 1'b1) begin n_err++; $display("FAIL basic_busy_high: got %0d expected 1", busy); end
      wait_done(3000);
      tick();
      n_chk++; if (wq_addr.size() - bw !== NPIX) begin n_err++; $display("FAIL basic_nwrites: got %0d expected %0d", wq_addr.size() - bw, NPIX); end
      if (wq_addr.size() - bw >= NPIX) begin
         for (int i = 0; i < NPIX; i++) begin
            exp_d = PW'(i % H) ^ PW'(i / H);
            n_chk++; if (wq_addr[bw+i] !== AW'(i)) begin n_err++; $display("FAIL basic_addr[%0d]: got %0d expected %0d", i, wq_addr[bw+i], i); end
            n_chk++; if (wq_data[bw+i] !== exp_d) begin n_err++; $display("FAIL basic_data[%0d]: got %0d expected %0d", i, wq_data[bw+i], exp_d); end
         end
      end
      n_chk++; if (done_total - bd !== 1) begin n_err++; $display("FAIL basic_done_pulses: got %0d expected 1", done_total - bd); end
      n_chk++; if (frame_count !== 8'd1) begin n_err++; $display("FAIL basic_count: got %0d expected 1", frame_count); end
      n_chk++; if (busy !== 1'b0) begin n_err++; $display("FAIL basic_busy_low: got %0d expected 0", busy); end
      n_chk++; if (en_cyc.size() - be !== NPIX) begin n_err++; $display("FAIL basic_nenables: got %0d expected %0d", en_cyc.size() - be, NPIX); end
      n_chk++; if (en_double !== 0) begin n_err++; $display("FAIL enable_double: got %0d expected 0", en_double); end
   endtask

   task automatic test_stall();
      int bw, ne, nw;
      bit seen;
      bw = wq_addr.size();
      pulse_start();
      seen = 1'b0;
      for (int c = 0; c < 2000; c++) begin
         tick();
         if (core_enable && core_x == 10'd1 && core_y == 9'd1) begin seen = 1'b1; break; end
      end
      n_chk++; if (!seen) begin n_err++; $display("FAIL stall_px5_issue: got 0 expected 1"); end
      drive_edge();
      stall = 1'b1;
      seen = 1'b0;
      for (int c = 0; c < 100; c++) begin
         tick();
         if (fb_we) begin seen = 1'b1; break; end
      end
      n_chk++; if (!seen) begin n_err++; $display("FAIL stall_we_rise: got 0 expected 1"); end
      ne = en_cyc.size();
      nw = wq_addr.size();
      for (int k = 0; k < 5; k++) begin
         n_chk++; if (fb_we !== 1'b1) begin n_err++; $display("FAIL stall_we[%0d]: got %0d expected 1", k, fb_we); end
         n_chk++; if (fb_addr !== AW'(5)) begin n_err++; $display("FAIL stall_addr[%0d]: got %0d expected 5", k, fb_addr); end
         n_chk++; if (fb_data !== 4'd0) begin n_err++; $display("FAIL stall_data[%0d]: got %0d expected 0", k, fb_data); end
         n_chk++; if (core_x !== 10'd1 || core_y !== 9'd1) begin n_err++; $display("FAIL stall_xy[%0d]: got %0d,%0d expected 1,1", k, core_x, core_y); end
         if (k < 4) tick();
      end
      n_chk++; if (en_cyc.size() !== ne) begin n_err++; $display("FAIL stall_reissue: got %0d expected %0d", en_cyc.size(), ne); end
      n_chk++; if (wq_addr.size() !== nw) begin n_err++; $display("FAIL stall_early_write: got %0d expected %0d", wq_addr.size(), nw); end
      drive_edge();
      stall = 1'b0;
      wait_done(3000);
      tick();
      n_chk++; if (wq_addr.size() - bw !== NPIX) begin n_err++; $display("FAIL stall_nwrites: got %0d expected %0d", wq_addr.size() - bw, NPIX); end
      if (wq_addr.size() - bw >= NPIX) begin
         for (int i = 0; i < NPIX; i++) begin
            n_chk++; if (wq_addr[bw+i] !== AW'(i)) begin n_err++; $display("FAIL stall_addr_seq[%0d]: got %0d expected %0d", i, wq_addr[bw+i], i); end
         end
      end
      n_chk++; if (frame_count !== 8'd2) begin n_err++; $display("FAIL stall_count: got %0d expected 2", frame_count); end
   endtask

   task automatic test_ack_timeout();
      int bw, be;
      bw = wq_addr.size();
      be = en_cyc.size();
      ignore_idx = core_en_seen;
      run_frame();
      tick();
      ignore_idx = -1;
      n_chk++; if (en_cyc.size() - be !== NPIX + 1) begin n_err++; $display("FAIL to_nenables: got %0d expected %0d", en_cyc.size() - be, NPIX + 1); end
      if (en_cyc.size() - be >= 2) begin
         n_chk++; if (en_x[be] !== 10'd0 || en_y[be] !== 9'd0 || en_x[be+1] !== 10'd0 || en_y[be+1] !== 9'd0) begin
            n_err++; $display("FAIL to_same_xy: got %0d,%0d then %0d,%0d expected 0,0 twice", en_x[be], en_y[be], en_x[be+1], en_y[be+1]);
         end
         // 8 WAIT_ACK cycles plus one ISSUE cycle between the two pulses
         n_chk++; if (en_cyc[be+1] - en_cyc[be] !== TO + 1) begin n_err++; $display("FAIL to_gap: got %0d expected %0d", en_cyc[be+1] - en_cyc[be], TO + 1); end
      end
      n_chk++; if (wq_addr.size() - bw !== NPIX) begin n_err++; $display("FAIL to_nwrites: got %0d expected %0d", wq_addr.size() - bw, NPIX); end
      if (wq_addr.size() - bw >= NPIX) begin
         for (int i = 0; i < NPIX; i++) begin
            n_chk++; if (wq_addr[bw+i] !== AW'(i)) begin n_err++; $display("FAIL to_addr_seq[%0d]: got %0d expected %0d", i, wq_addr[bw+i], i); end
         end
      end
      n_chk++; if (frame_count !== 8'd3) begin n_err++; $display("FAIL to_count: got %0d expected 3", frame_count); end
   endtask

   task automatic test_reset_mid();
      int bw;
      bit seen;
      pulse_start();
      seen = 1'b0;
      for (int c = 0; c < 2000; c++) begin
         tick();
         if (core_enable && core_x == 10'd3 && core_y == 9'd1) begin seen = 1'b1; break; end
      end
      n_chk++; if (!seen) begin n_err++; $display("FAIL rmid_px7_issue: got 0 expected 1"); end
      for (int c = 0; c < 20; c++) begin
         if (!core_ready) break;
         tick();
      end
      drive_edge();
      n_chk++; if (busy !== 1'b1 || core_x !== 10'd3) begin n_err++; $display("FAIL rmid_pre: got busy=%0d x=%0d expected 1,3", busy, core_x); end
      rst = 1'b1;
      #1;
      n_chk++; if (busy !== 1'b0) begin n_err++; $display("FAIL rmid_busy: got %0d expected 0", busy); end
      n_chk++; if (core_x !== 10'd0 || core_y !== 9'd0) begin n_err++; $display("FAIL rmid_xy: got %0d,%0d expected 0,0", core_x, core_y); end
      n_chk++; if (fb_addr !== '0 || fb_data !== '0) begin n_err++; $display("FAIL rmid_fb: got %0d,%0d expected 0,0", fb_addr, fb_data); end
      n_chk++; if (fb_we !== 1'b0 || core_enable !== 1'b0 || frame_done !== 1'b0) begin n_err++; $display("FAIL rmid_strobes: got %0d%0d%0d expected 000", fb_we, core_enable, frame_done); end
      n_chk++; if (frame_count !== 8'd0) begin n_err++; $display("FAIL rmid_count: got %0d expected 0", frame_count); end
      drive_edge();
      drive_edge();
      rst = 1'b0;
      bw = wq_addr.size();
      run_frame();
      tick();
      n_chk++; if (wq_addr.size() - bw !== NPIX) begin n_err++; $display("FAIL rmid_nwrites: got %0d expected %0d", wq_addr.size() - bw, NPIX); end
      if (wq_addr.size() - bw >= NPIX) begin
         for (int i = 0; i < NPIX; i++) begin
            n_chk++; if (wq_addr[bw+i] !== AW'(i)) begin n_err++; $display("FAIL rmid_addr_seq[%0d]: got %0d expected %0d", i, wq_addr[bw+i], i); end
         end
      end
      n_chk++; if (frame_count !== 8'd1) begin n_err++; $display("FAIL rmid_count_after: got %0d expected 1", frame_count); end
   endtask

   task automatic test_back_to_back();
      int bw, bd;
      do_reset();
      bw = wq_addr.size();
      bd = done_total;
      pulse_start();
      for (int c = 0; c < 2000; c++) begin
         tick();
         if (wq_addr.size() - bw >= 4) break;
      end
      pulse_start();
      for (int c = 0; c < 2000; c++) begin
         tick();
         if (wq_addr.size() - bw >= 10) break;
      end
      drive_edge();
      start = 1'b1;
      wait_done(3000);
      tick();
      n_chk++; if (busy !== 1'b0) begin n_err++; $display("FAIL b2b_idle_busy: got %0d expected 0", busy); end
      tick();
      n_chk++; if (busy !== 1'b1) begin n_err++; $display("FAIL b2b_restart_busy: got %0d expected 1", busy); end
      drive_edge();
      start = 1'b0;
      wait_done(3000);
      tick();
      n_chk++; if (wq_addr.size() - bw !== 2 * NPIX) begin n_err++; $display("FAIL b2b_nwrites: got %0d expected %0d", wq_addr.size() - bw, 2 * NPIX); end
      if (wq_addr.size() - bw >= 2 * NPIX) begin
         for (int i = 0; i < 2 * NPIX; i++) begin
            n_chk++; if (wq_addr[bw+i] !== AW'(i % NPIX)) begin n_err++; $display("FAIL b2b_addr_seq[%0d]: got %0d expected %0d", i, wq_addr[bw+i], i % NPIX); end
         end
      end
      n_chk++; if (done_total - bd !== 2) begin n_err++; $display("FAIL b2b_done_pulses: got %0d expected 2", done_total - bd); end
      n_chk++; if (frame_count !== 8'd2) begin n_err++; $display("FAIL b2b_count: got %0d expected 2", frame_count); end
   endtask

   task automatic test_count_wrap();
      do_reset();
      for (int f = 0; f < 255; f++) run_frame();
      tick();
      n_chk++; if (frame_count !== 8'd255) begin n_err++; $display("FAIL wrap_255: got %0d expected 255", frame_count); end
      run_frame();
      tick();
      n_chk++; if (frame_count !== 8'd0) begin n_err++; $display("FAIL wrap_0: got %0d expected 0", frame_count); end
      n_chk++; if (en_double !== 0) begin n_err++; $display("FAIL enable_double_end: got %0d expected 0", en_double); end
   endtask

   initial begin
      test_reset();
      test_basic_frame();
      test_stall();
      test_ack_timeout();
      test_reset_mid();
      test_back_to_back();
      test_count_wrap();
      $display("Result: errors=%0d of %0d checks", n_err, n_chk);
      $finish;
   end

   initial begin
      #5ms;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

endmodule
